// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register file and its dump reader: file geometry
// and the dump FSM state encoding.
package reg_dump_reader_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int NUM_REGS       = 32;

    typedef logic [1:0] dumpState_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Control, register-file read port and dump stream of the dump reader.
// Dump stream: a word moves on every rising edge where DumpValid & DumpReady;
// while DumpValid is high and not yet accepted, DumpData/DumpIndex stay fixed.
interface reg_dump_reader_if
    import reg_dump_reader_pkg::*;
#(
    parameter int WIDTH      = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
);

    logic                  Start;
    logic                  Abort;
    logic [ADDR_WIDTH-1:0] ReadRegister;
    logic [WIDTH-1:0]      ReadData;
    logic                  DumpValid;
    logic                  DumpReady;
    logic [WIDTH-1:0]      DumpData;
    logic [ADDR_WIDTH-1:0] DumpIndex;
    logic                  Busy;
    logic                  Done;
    logic [WIDTH-1:0]      Checksum;
    logic                  ZeroError;
    dumpState_t            DebugState;

    modport master (
        input  Start, Abort, ReadData, DumpReady,
        output ReadRegister, DumpValid, DumpData, DumpIndex,
               Busy, Done, Checksum, ZeroError, DebugState
    );

    modport slave (
        output Start, Abort, ReadData, DumpReady,
        input  ReadRegister, DumpValid, DumpData, DumpIndex,
               Busy, Done, Checksum, ZeroError, DebugState
    );

endinterface

// File: rtl/reg_dump_reader.sv
// Walks a register file read port over FIRST_REG..LAST_REG, streaming each word
// with its index while accumulating an additive checksum and a register-0 check.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int WIDTH      = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int FIRST_REG  = 0,
    parameter int LAST_REG   = NUM_REGS - 1
) (
    input  logic             Clk,
    input  logic             ResetN,
    reg_dump_reader_if.master bus
);

    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG >= (1 << ADDR_WIDTH)) begin : gBadRange
        $error("reg_dump_reader: FIRST_REG/LAST_REG outside 0..2**ADDR_WIDTH-1 or reversed");
    end

    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(FIRST_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(LAST_REG);

    dumpState_t            state;
    logic [ADDR_WIDTH-1:0] readRegister;
    logic                  dumpValid;
    logic [WIDTH-1:0]      dumpData;
    logic [ADDR_WIDTH-1:0] dumpIndex;
    logic [WIDTH-1:0]      checksum;
    logic                  zeroError;
    logic                  transfer;

    assign transfer = dumpValid & bus.DumpReady;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state        <= ST_IDLE;
            readRegister <= FIRST_ADDR;
            dumpValid    <= 1'b0;
            dumpData     <= '0;
            dumpIndex    <= '0;
            checksum     <= '0;
            zeroError    <= 1'b0;
        end else if (state != ST_IDLE && bus.Abort) begin
            // Abort wins over a pending transfer; partial checksum is kept.
            state     <= ST_IDLE;
            dumpValid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        state        <= ST_FETCH;
                        readRegister <= FIRST_ADDR;
                        checksum     <= '0;
                        zeroError    <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    dumpData  <= bus.ReadData;
                    dumpIndex <= readRegister;
                    dumpValid <= 1'b1;
                    state     <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (transfer) begin
                        checksum  <= checksum + dumpData;
                        dumpValid <= 1'b0;
                        if (dumpIndex == '0 && dumpData != '0) begin
                            zeroError <= 1'b1;
                        end
                        // Stop at LAST_ADDR without incrementing so the address never wraps.
                        if (dumpIndex == LAST_ADDR) begin
                            state <= ST_DONE;
                        end else begin
                            readRegister <= readRegister + ADDR_WIDTH'(1);
                            state        <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ReadRegister = readRegister;
    assign bus.DumpValid    = dumpValid;
    assign bus.DumpData     = dumpData;
    assign bus.DumpIndex    = dumpIndex;
    assign bus.Busy         = (state == ST_FETCH) || (state == ST_PRESENT);
    assign bus.Done         = (state == ST_DONE);
    assign bus.Checksum     = checksum;
    assign bus.ZeroError    = zeroError;
    assign bus.DebugState   = state;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: table-driven full dumps against a register-file
// model and scoreboard, plus narrow-range, abort and mid-dump reset sequences.
module tb_reg_dump_reader;
    import reg_dump_reader_pkg::*;

    localparam int W  = REG_DATA_WIDTH;
    localparam int AW = REG_ADDR_WIDTH;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic ResetN = 1'b0;
    always #5 Clk = ~Clk;

    reg_dump_reader_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();
    reg_dump_reader_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus2 ();

    reg_dump_reader #(.WIDTH(W), .ADDR_WIDTH(AW), .FIRST_REG(0), .LAST_REG(31))
        dut (.Clk(Clk), .ResetN(ResetN), .bus(bus));
    reg_dump_reader #(.WIDTH(W), .ADDR_WIDTH(AW), .FIRST_REG(30), .LAST_REG(31))
        dut2 (.Clk(Clk), .ResetN(ResetN), .bus(bus2));

    // Register file: register 0 reads zero unless the stub forces 50 there.
    logic [W-1:0] regFile [NUM_REGS];
    logic         stubZero;
    assign bus.ReadData  = (stubZero && bus.ReadRegister == '0) ? W'(50) : regFile[bus.ReadRegister];
    assign bus2.ReadData = regFile[bus2.ReadRegister];

    int vecCount  = 0;
    int missCount = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0]  exp_q[$];
    logic [AW-1:0] expIdx_q[$];
    bit            monEnable = 1'b0;
    bit            prevStall = 1'b0;
    logic [W-1:0]  prevData;
    logic [AW-1:0] prevIdx;

    always @(negedge Clk) begin
        if (monEnable) begin
            if (prevStall && bus.DumpValid) begin
                check("hold_data", bus.DumpData, prevData);
                check("hold_index", bus.DumpIndex, prevIdx);
            end
            if (bus.DumpValid && bus.DumpReady) begin
                vecCount++;
                if (exp_q.size() == 0) begin
                    missCount++;
                    $display("FAIL extra_word: got index %0d, expected no word", bus.DumpIndex);
                end else begin
                    vecCount--;
                    check("word_data", bus.DumpData, exp_q.pop_front());
                    check("word_index", bus.DumpIndex, expIdx_q.pop_front());
                end
            end
            prevStall = bus.DumpValid && !bus.DumpReady;
            prevData  = bus.DumpData;
            prevIdx   = bus.DumpIndex;
        end else begin
            prevStall = 1'b0;
        end
    end

    // ---------------- register file drivers and model ----------------
    task automatic writeReg(input int a, input logic [W-1:0] d, input bit we);
        if (we && a != 0) regFile[a] = d;
    endtask

    task automatic fillRegs(input int fill);
        for (int k = 0; k < NUM_REGS; k++) regFile[k] = '0;
        case (fill)
            0: for (int k = 1; k < NUM_REGS; k++) writeReg(k, W'(k), 1'b1);
            1: begin
                writeReg(17, 32'hDEADBEEF, 1'b1);
                writeReg(23, 32'h00BADA55, 1'b0);
            end
            default: for (int k = 1; k < NUM_REGS; k++) writeReg(k, W'($urandom()), 1'b1);
        endcase
    endtask

    // Expected stream: every register in range, in order, as the read port shows it.
    task automatic buildExpect(input int first, input int last,
                               output logic [W-1:0] sum, output bit zero);
        logic [W-1:0] d;
        sum  = '0;
        zero = 1'b0;
        exp_q.delete();
        expIdx_q.delete();
        for (int idx = first; idx <= last; idx++) begin
            d = (idx == 0 && stubZero) ? W'(50) : regFile[idx];
            exp_q.push_back(d);
            expIdx_q.push_back(AW'(idx));
            sum += d;
            if (idx == 0 && d != '0) zero = 1'b1;
        end
    endtask

    task automatic checkReset(string tag);
        check({tag, "_ReadRegister"}, bus.ReadRegister, 0);
        check({tag, "_DumpValid"}, bus.DumpValid, 0);
        check({tag, "_DumpData"}, bus.DumpData, 0);
        check({tag, "_DumpIndex"}, bus.DumpIndex, 0);
        check({tag, "_Busy"}, bus.Busy, 0);
        check({tag, "_Done"}, bus.Done, 0);
        check({tag, "_Checksum"}, bus.Checksum, 0);
        check({tag, "_ZeroError"}, bus.ZeroError, 0);
        check({tag, "_State"}, bus.DebugState, ST_IDLE);
    endtask

    // Pulses Start, then counts edges from the accept edge to the Done cycle.
    task automatic runDump(input bit readyRandom, input bit checkZeroEarly,
                           input bit expZero, output int cycles);
        bus.DumpReady = 1'b1;
        @(posedge Clk); #1 bus.Start = 1'b1;
        @(posedge Clk); #1 bus.Start = 1'b0;
        cycles = -1;
        for (int c = 0; c < 2000; c++) begin
            if (readyRandom) bus.DumpReady = 1'($urandom_range(0, 1));
            @(negedge Clk);
            if (c == 0) begin
                check("start_clears_checksum", bus.Checksum, 0);
                check("start_clears_zero", bus.ZeroError, 0);
                check("start_busy", bus.Busy, 1);
                check("start_state", bus.DebugState, ST_FETCH);
            end
            if (c == 3 && checkZeroEarly) check("zero_after_first", bus.ZeroError, expZero);
            if (bus.Done) begin
                cycles = c;
                break;
            end
            @(posedge Clk); #1;
        end
        if (cycles < 0) begin
            vecCount++;
            missCount++;
            $display("FAIL done_timeout: got no Done, expected Done within 2000 cycles");
        end else begin
            check("zero_at_done", bus.ZeroError, expZero);
            @(posedge Clk); #1;
            check("done_one_cycle", bus.Done, 0);
            check("idle_not_busy", bus.Busy, 0);
        end
        bus.DumpReady = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int           fill;
        bit           readyRandom;
        bit           stub;
        bit           useModel;
        logic [W-1:0] expSum;
        bit           expZero;
        int           expCycles;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [W-1:0]  mSum;
        bit            mZero;
        int            cyc;
        int            minAddr;
        bit            doneSeen;
        logic [W-1:0]  got2Data[$];
        logic [AW-1:0] got2Idx[$];

        vecs[0] = '{fill: 0, readyRandom: 0, stub: 0, useModel: 0, expSum: 32'h000001F0, expZero: 0, expCycles: 64};
        vecs[1] = '{fill: 1, readyRandom: 0, stub: 0, useModel: 0, expSum: 32'hDEADBEEF, expZero: 0, expCycles: 64};
        vecs[2] = '{fill: 0, readyRandom: 1, stub: 0, useModel: 0, expSum: 32'h000001F0, expZero: 0, expCycles: -1};
        vecs[3] = '{fill: 0, readyRandom: 0, stub: 1, useModel: 0, expSum: 32'h00000222, expZero: 1, expCycles: 64};
        vecs[4] = '{fill: 2, readyRandom: 1, stub: 0, useModel: 1, expSum: '0, expZero: 0, expCycles: -1};

        bus.Start = 1'b0;  bus.Abort = 1'b0;  bus.DumpReady = 1'b0;
        bus2.Start = 1'b0; bus2.Abort = 1'b0; bus2.DumpReady = 1'b0;
        stubZero = 1'b0;
        fillRegs(0);

        repeat (3) @(posedge Clk);
        #1 checkReset("reset");
        check("reset2_ReadRegister", bus2.ReadRegister, 30);
        @(negedge Clk) ResetN = 1'b1;

        for (int i = 0; i < 5; i++) begin
            stubZero = vecs[i].stub;
            fillRegs(vecs[i].fill);
            buildExpect(0, 31, mSum, mZero);
            monEnable = 1'b1;
            runDump(vecs[i].readyRandom, !vecs[i].readyRandom && vecs[i].stub,
                    vecs[i].useModel ? mZero : vecs[i].expZero, cyc);
            monEnable = 1'b0;
            check("words_left", exp_q.size(), 0);
            check("checksum", bus.Checksum, vecs[i].useModel ? mSum : vecs[i].expSum);
            check("zero_hold", bus.ZeroError, vecs[i].useModel ? mZero : vecs[i].expZero);
            check("last_addr_no_wrap", bus.ReadRegister, 31);
            if (vecs[i].expCycles >= 0) check("done_latency", cyc, vecs[i].expCycles);
            if (vecs[i].fill == 1) check("blocked_write_23", regFile[23], 0);
        end
        stubZero = 1'b0;

        // Narrow range 30..31 on the second instance.
        fillRegs(0);
        bus2.DumpReady = 1'b1;
        minAddr = 31;
        cyc = -1;
        @(posedge Clk); #1 bus2.Start = 1'b1;
        @(posedge Clk); #1 bus2.Start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge Clk);
            if (int'(bus2.ReadRegister) < minAddr) minAddr = int'(bus2.ReadRegister);
            if (bus2.DumpValid && bus2.DumpReady) begin
                got2Data.push_back(bus2.DumpData);
                got2Idx.push_back(bus2.DumpIndex);
            end
            if (bus2.Done) begin
                cyc = c;
                break;
            end
            @(posedge Clk); #1;
        end
        check("range_done_latency", cyc, 4);
        check("range_word_count", got2Data.size(), 2);
        if (got2Data.size() == 2) begin
            check("range_idx0", got2Idx[0], 30);
            check("range_data0", got2Data[0], 30);
            check("range_idx1", got2Idx[1], 31);
            check("range_data1", got2Data[1], 31);
        end
        check("range_min_addr", minAddr, 30);
        check("range_max_addr", bus2.ReadRegister, 31);
        check("range_checksum", bus2.Checksum, 61);

        // Abort while presenting index 5 with DumpReady high.
        bus.DumpReady = 1'b1;
        cyc = -1;
        @(posedge Clk); #1 bus.Start = 1'b1;
        @(posedge Clk); #1 bus.Start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge Clk);
            if (bus.DumpValid && bus.DumpIndex == AW'(5)) begin
                cyc = c;
                break;
            end
        end
        check("abort_reached_idx5", cyc >= 0, 1);
        bus.Abort = 1'b1;
        @(posedge Clk); #1 bus.Abort = 1'b0;
        check("abort_valid", bus.DumpValid, 0);
        check("abort_busy", bus.Busy, 0);
        check("abort_state", bus.DebugState, ST_IDLE);
        check("abort_partial_checksum", bus.Checksum, 10);
        doneSeen = 1'b0;
        repeat (6) begin
            @(negedge Clk);
            if (bus.Done) doneSeen = 1'b1;
        end
        check("abort_no_done", doneSeen, 0);

        // Reset in the middle of a dump, then a clean dump.
        @(posedge Clk); #1 bus.Start = 1'b1;
        @(posedge Clk); #1 bus.Start = 1'b0;
        repeat (20) @(posedge Clk);
        @(negedge Clk) ResetN = 1'b0;
        #1 checkReset("midreset");
        @(negedge Clk) ResetN = 1'b1;
        buildExpect(0, 31, mSum, mZero);
        monEnable = 1'b1;
        runDump(1'b0, 1'b0, 1'b0, cyc);
        monEnable = 1'b0;
        check("post_reset_words_left", exp_q.size(), 0);
        check("post_reset_checksum", bus.Checksum, 32'h000001F0);
        check("post_reset_latency", cyc, 64);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
